// File: rtl/block_ram_pkg.sv
// Shared types and constants for the dual-port block RAM.
// BLOCK_RAM_OUTREG_EN selects the two-stage output pipeline (read latency 2).
package block_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int lanes_of(input int width);
    return width / 8;
  endfunction

`ifdef BLOCK_RAM_OUTREG_EN
  localparam int BRAM_READ_LATENCY = 2;
`else
  localparam int BRAM_READ_LATENCY = 1;
`endif

endpackage

// File: rtl/block_ram_dp_if.sv
// Bus bundle for block_ram_dp: write port A, read port B and init status.
interface block_ram_dp_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int BYTE_LANES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [BYTE_LANES-1:0] wea;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  reb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  doutb_valid;
  logic                  init_busy;

  modport master (
    output addra, dina, wea, addrb, reb,
    input  doutb, doutb_valid, init_busy
  );

  modport slave (
    input  addra, dina, wea, addrb, reb,
    output doutb, doutb_valid, init_busy
  );
endinterface

// File: rtl/block_ram_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every word once, then hands over to RUN.
//   state | meaning
//   INIT  | writing zero to mem[cnt] each cycle, external ports blocked
//   RUN   | sweep finished, external reads/writes accepted
module block_ram_init_seq
  import block_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rst,
  output logic                  o_init_we,
  output logic [ADDR_WIDTH-1:0] o_init_addr,
  output logic                  o_init_busy
);
  // Extra counter bit keeps the terminal compare from wrapping back to 0.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_WIDTH:0] r_cnt;
  logic [ADDR_WIDTH:0] w_cnt_nxt;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_init_we   = 1'b0;
    o_init_busy = 1'b0;
    o_init_addr = r_cnt[ADDR_WIDTH-1:0];
    case (r_state)
      INIT: begin
        o_init_we   = 1'b1;
        o_init_busy = 1'b1;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end
endmodule

// File: rtl/block_ram_dp.sv
// Simple dual-port byte-lane RAM with zero-fill after reset and write-first collisions.
// BLOCK_RAM_OUTREG_EN adds a second output register stage (see block_ram_pkg).
module block_ram_dp
  import block_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clka,
  input  logic           rst,
  block_ram_dp_if.slave  bus
);
  localparam int BYTE_LANES = lanes_of(DATA_WIDTH);
  localparam int DEPTH      = 2**ADDR_WIDTH;

  logic                  w_init_we;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_init_busy;
  logic                  w_rd_en;
  logic [BYTE_LANES-1:0] w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_rd_lane [BYTE_LANES];
  logic [DATA_WIDTH-1:0] w_merged;
  logic [BYTE_LANES-1:0] r_fwd_mask;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic                  r_valid1;

  block_ram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_seq (
    .clka        (clka),
    .rst         (rst),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_busy (w_init_busy)
  );

  assign w_rd_en = bus.reb & ~w_init_busy;
  assign w_we    = w_init_we ? {BYTE_LANES{1'b1}} : bus.wea;
  assign w_waddr = w_init_we ? w_init_addr : bus.addra;
  assign w_wdata = w_init_we ? '0 : bus.dina;

  for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clka) begin
      if (w_we[gi]) r_mem[w_waddr] <= w_wdata[8*gi +: 8];
    end

    // Read-first array port; the collision fix-up happens after this register.
    always_ff @(posedge clka or posedge rst) begin
      if (rst)          r_q <= '0;
      else if (w_rd_en) r_q <= r_mem[bus.addrb];
    end

    assign w_rd_lane[gi] = r_q;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
      r_valid1   <= 1'b0;
    end else begin
      r_valid1 <= w_rd_en;
      if (w_rd_en) begin
        r_fwd_mask <= (bus.addra == bus.addrb) ? bus.wea : '0;
        r_fwd_data <= bus.dina;
      end
    end
  end

  always_comb begin
    w_merged = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      w_merged[8*i +: 8] = r_fwd_mask[i] ? r_fwd_data[8*i +: 8] : w_rd_lane[i];
    end
  end

  if (BRAM_READ_LATENCY > 1) begin : g_outreg
    logic [DATA_WIDTH-1:0] r_dout2;
    logic                  r_valid2;

    always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
        r_dout2  <= '0;
        r_valid2 <= 1'b0;
      end else begin
        r_dout2  <= w_merged;
        r_valid2 <= r_valid1;
      end
    end

    assign bus.doutb       = r_dout2;
    assign bus.doutb_valid = r_valid2;
  end else begin : g_direct
    assign bus.doutb       = w_merged;
    assign bus.doutb_valid = r_valid1;
  end

  assign bus.init_busy = w_init_busy;
endmodule

// File: doc/block_ram_dp.md
# block_ram_dp

Parametrised simple-dual-port block RAM with per-byte write enables. It is the successor to the fixed 32-bit program/data RAM in the peripherals tree. It adds a configurable data width, a read-enable/valid handshake, write-first forwarding on same-address collisions, and a hardware zero-fill sweep after reset. It sits behind the bus-to-memory bridges: port A is write-only and port B is read-only, both on the same clock.

## Interface
Parameters:
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8, legal range 8..128
- BYTE_LANES, DATA_WIDTH/8, derived, not overridden

Ports:
- clka  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- addra  in  ADDR_WIDTH  write word address
- dina  in  DATA_WIDTH  write data; lane i = dina[8i+7:8i]
- wea  in  BYTE_LANES  per-lane write enable
- addrb  in  ADDR_WIDTH  read word address
- reb  in  1  read request, sampled each cycle
- doutb  out  DATA_WIDTH  read data; reset 0
- doutb_valid  out  1  doutb carries the data for an accepted read this cycle; reset 0
- init_busy  out  1  zero-fill sweep in progress; reset 1

## Operation
- FSM states: INIT, RUN. Reset forces INIT, clears the sweep counter to 0, and clears doutb, doutb_valid and all pipeline registers to 0.
- INIT:
  - Each cycle writes all-zero to mem[cnt], then increments cnt.
  - When cnt == 2**ADDR_WIDTH-1, that write completes and the FSM moves to RUN on the next edge.
  - wea is ignored and external writes are dropped.
  - reb is ignored: doutb_valid stays 0 and doutb holds its value.
  - init_busy = 1.
- RUN: init_busy = 0.
  - Write: for each lane i with wea[i]=1, mem[addra] lane i <= dina lane i at the rising edge. Lanes with wea[i]=0 are unchanged.
  - Read: when reb=1, the read is accepted and the data appears per the Timing section. When reb=0, doutb holds its last value and doutb_valid drops to 0.
  - Collision (reb=1, addra==addrb, any wea set, same cycle): write-first. Returned lane i = dina lane i if wea[i], otherwise the stored lane. Never return X or stale data for an enabled lane.
- The sweep counter is ADDR_WIDTH+1 bits wide, so the terminal compare does not wrap. Address ports use modulo-depth addressing; there is no out-of-range condition.
- rst asserted mid-INIT or mid-RUN: the sweep restarts from address 0 and any in-flight read is discarded (valid 0). Memory contents before the restart are don't-care.

## Timing
- Without BLOCK_RAM_OUTREG_EN: read latency is 1. A read accepted at edge N has doutb/doutb_valid valid after edge N.
- With BLOCK_RAM_OUTREG_EN: read latency is 2. doutb_valid is pipelined alongside the data.
- Back-to-back reads are allowed every cycle; throughput is 1 read and 1 write per cycle.
- Zero-fill takes exactly 2**ADDR_WIDTH cycles from reset release. init_busy falls on the edge the FSM enters RUN, and the first accepted read/write happens in that same cycle.
- Write-to-read across cycles: a write at edge N is visible to a read accepted at edge N+1.

## Configuration
- Macro: BLOCK_RAM_OUTREG_EN.
- Defined: adds a second output register stage for doutb and doutb_valid, so read latency is 2. The stage is reset to 0 and is intended for timing closure at high clka.
- Undefined: a single output register, read latency 1.
- Forwarding, init and handshake behaviour are identical apart from the added cycle.

## Structure
- Shared package block_ram_pkg:
  - state enum (INIT, RUN)
  - function lanes_of(width)
  - constant BRAM_READ_LATENCY, set by BLOCK_RAM_OUTREG_EN
- Sub-module block_ram_init_seq holds the FSM and sweep counter. Outputs: init_we, init_addr, init_busy.
- The top level muxes init vs. port-A write, and holds the byte-lane array, the forwarding merge and the output pipeline.
- The array must stay inferable as block RAM:
  - no reset on the memory itself
  - one write process per lane
  - forwarding merge performed on the registered read path

## Test plan
- Reset release with ADDR_WIDTH=4: init_busy high for exactly 16 cycles. Then reading all 16 addresses returns 0x00000000 with doutb_valid at the configured latency.
- RUN, write addr 3 dina=0xA1B2C3D4 wea=4'b1111, then wea=4'b0101 dina=0x11223344 → read addr 3 returns 0xA122C344.
- Same cycle: addra=addrb=7, reb=1, wea=4'b0011, dina=0xDEADBEEF, old mem[7]=0x12345678 → doutb=0x1234BEEF.
- Writes attempted during INIT (addr 5, 0xFFFFFFFF, wea all) → after init, a read of addr 5 returns 0.
- reb pattern 1,0,1 on addrs 1,2,3 → doutb_valid pattern 1,0,1 delayed by the latency; doutb holds addr 1 data during the gap. Run with and without BLOCK_RAM_OUTREG_EN.
- rst pulsed mid-sweep (cycle 9 of 16) and during a read: doutb=0 and valid=0 immediately, init_busy=1, and a full 16-cycle sweep is observed again.
